// File: rtl/wbc_arb_pkg.sv
// wbc_arb_pkg: shared state encoding, master indices and sizing helper for the control-fabric arbiter
package wbc_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    localparam int BMC   = 0;
    localparam int SPIC  = 1;
    localparam int PCIEC = 2;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/wbc_master_arbiter_if.sv
// wbc_master_arbiter_if: WISHBONE classic bundle between the masters, the arbiter and the intercon
interface wbc_master_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 22,
    parameter int SEL_WIDTH   = 4
);
    logic [NUM_MASTERS-1:0]            m_cyc_i;
    logic [NUM_MASTERS-1:0]            m_stb_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
    logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
    logic [DATA_WIDTH-1:0]             m_dat_o;
    logic [NUM_MASTERS-1:0]            m_ack_o;
    logic [NUM_MASTERS-1:0]            m_err_o;
    logic [NUM_MASTERS-1:0]            m_rty_o;
    logic                              s_cyc_o;
    logic                              s_stb_o;
    logic                              s_we_o;
    logic [ADDR_WIDTH-1:0]             s_adr_o;
    logic [DATA_WIDTH-1:0]             s_dat_o;
    logic [SEL_WIDTH-1:0]              s_sel_o;
    logic [DATA_WIDTH-1:0]             s_dat_i;
    logic                              s_ack_i;
    logic                              s_err_i;
    logic                              s_rty_i;

    // arbiter view: it is the single bus master facing the intercon
    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

    // environment view: requesting masters plus the slave side
    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick, first requester at or above the pointer, wrapping
module rr_priority_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // scan from the farthest offset down so the nearest requester is the last write
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + i) % N] = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/wbc_master_arbiter.sv
// wbc_master_arbiter: round-robin, cycle-locked sharing of the control fabric with a hung-slave watchdog
module wbc_master_arbiter
    import wbc_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 22,
    parameter int SEL_WIDTH     = 4,
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = 8,
    localparam int IW           = clog2_min1(NUM_MASTERS)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    wbc_master_arbiter_if.master   bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o,
    output logic [IW-1:0]          timeout_master_o
);

    state_t                   state;
    logic [IW-1:0]            ptr;
    logic [IW-1:0]            gidx;
    logic [IW-1:0]            pick_idx;
    logic [IW-1:0]            next_ptr;
    logic [NUM_MASTERS-1:0]   pick_gnt;
    logic [TIMEOUT_WIDTH-1:0] cnt;
    logic                     busy;
    logic                     term;
    logic                     abort;

    rr_priority_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req (bus.m_cyc_i),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign busy     = state == BUSY;
    assign term     = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
    assign abort    = TIMEOUT != 0 && bus.s_stb_o && !term && cnt == TIMEOUT_WIDTH'(TIMEOUT - 1);
    assign next_ptr = gidx == IW'(NUM_MASTERS - 1) ? '0 : gidx + 1'b1;

    // only a live tenure reaches the intercon; IDLE and ABORT present an inert bus
    assign bus.s_cyc_o = busy & bus.m_cyc_i[gidx];
    assign bus.s_stb_o = busy & bus.m_stb_i[gidx];
    assign bus.s_we_o  = busy & bus.m_we_i[gidx];
    assign bus.s_adr_o = busy ? bus.m_adr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.s_dat_o = busy ? bus.m_dat_i[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.s_sel_o = busy ? bus.m_sel_i[gidx*SEL_WIDTH +: SEL_WIDTH] : '0;

    // terminations go only to the granted master, and only while BUSY
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_ack_o = {NUM_MASTERS{busy & bus.s_ack_i}} & grant_o;
    assign bus.m_err_o = {NUM_MASTERS{(busy & bus.s_err_i) | abort}} & grant_o;
    assign bus.m_rty_o = {NUM_MASTERS{busy & bus.s_rty_i}} & grant_o;
    assign timeout_o   = abort;

    // grant FSM with watchdog; a tenure ends only when the owner drops cyc
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            grant_o          <= '0;
            ptr              <= '0;
            gidx             <= '0;
            cnt              <= '0;
            timeout_master_o <= '0;
        end else begin
            cnt <= (bus.s_stb_o && !term && !abort && bus.m_cyc_i[gidx]) ? cnt + 1'b1 : '0;
            case (state)
                IDLE: if (|bus.m_cyc_i) begin
                    grant_o <= pick_gnt;
                    gidx    <= pick_idx;
                    state   <= BUSY;
                end
                default: if (!bus.m_cyc_i[gidx]) begin
                    grant_o <= '0;
                    ptr     <= next_ptr;
                    state   <= IDLE;
                end else if (abort) begin
                    timeout_master_o <= gidx;
                    state            <= ABORT;
                end
            endcase
        end
    end

endmodule
